// File: rtl/mdu_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// mult/multu and div/divu hold Busy for a fixed cycle count and then pulse Done.
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NOP7  = 3'd7
    } op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    logic [2*WIDTH-1:0]      prod_s, prod_u;
    logic [WIDTH-1:0]        div_b, quot_u, rem_u;
    logic signed [WIDTH-1:0] quot_s, rem_s;
    logic                    div_zero, div_ovf;

    always_comb begin
        prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        div_zero = (b_q == '0);
        div_ovf  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        // Substitute a safe divisor so the dividers never see zero; the result is discarded then.
        div_b    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
        quot_u   = a_q / div_b;
        rem_u    = a_q % div_b;
        quot_s   = $signed(a_q) / $signed(div_b);
        rem_s    = $signed(a_q) % $signed(div_b);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (op_e'(MDUOp))
                        OP_MULT, OP_MULTU: begin
                            state_d = BUSY;
                            op_d    = op_e'(MDUOp);
                            cnt_d   = 8'(MULT_CYCLES);
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = BUSY;
                            op_d    = op_e'(MDUOp);
                            cnt_d   = 8'(DIV_CYCLES);
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[2*WIDTH-1:WIDTH];
                            lo_d = prod_s[WIDTH-1:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[2*WIDTH-1:WIDTH];
                            lo_d = prod_u[WIDTH-1:0];
                        end
                        OP_DIV: begin
                            if (div_ovf) begin
                                hi_d = '0;
                                lo_d = a_q;
                            end else if (!div_zero) begin
                                hi_d = rem_s;
                                lo_d = quot_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                hi_d = rem_u;
                                lo_d = quot_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Busy = (state_q == BUSY);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: default 32-bit instance plus a 16-bit, short-latency instance.
module tb_mdu_unit;

    logic        Clk;
    logic        Rst;
    logic        Start, Start2;
    logic [2:0]  MDUOp, MDUOp2;
    logic [31:0] A, B, HI, LO;
    logic [15:0] A2, B2, HI2, LO2;
    logic        Busy, Done, Busy2, Done2;

    int checks   = 0;
    int failures = 0;
    int n;
    logic saw_done;

    mdu_unit dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .Clk(Clk), .Rst(Rst), .Start(Start2), .MDUOp(MDUOp2), .A(A2), .B(B2),
        .Busy(Busy2), .Done(Done2), .HI(HI2), .LO(LO2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; A = ~a; B = ~b;
    endtask

    task automatic launch2(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        MDUOp2 = op; A2 = a; B2 = b; Start2 = 1'b1;
        tick();
        Start2 = 1'b0; A2 = ~a; B2 = ~b;
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (Busy && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_busy2(output int cnt);
        cnt = 0;
        while (Busy2 && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        Rst = 1'b0;
        Start = 1'b1; MDUOp = 3'd1; A = 32'd3; B = 32'd4;
        Start2 = 1'b0; MDUOp2 = 3'd0; A2 = '0; B2 = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);

        // Start held across reset release: accepted at the first edge with Rst high
        Rst = 1'b1;
        tick();
        Start = 1'b0;
        chk("first_start_busy", 64'(Busy), 64'd1);
        wait_busy(n);
        chk("first_mult_cycles", 64'(n), 64'd5);
        chk("first_mult_done", 64'(Done), 64'd1);
        chk("first_mult_lo", 64'(LO), 64'd12);
        tick();
        chk("done_one_cycle", 64'(Done), 64'd0);

        launch(3'd5, 32'h1234_5678, 32'h0);
        chk("mthi_hi", 64'(HI), 64'h1234_5678);
        chk("mthi_busy", 64'(Busy), 64'd0);
        launch(3'd6, 32'h1234_5678, 32'h0);
        chk("mtlo_lo", 64'(LO), 64'h1234_5678);

        launch(3'd4, 32'd7, 32'd0);
        wait_busy(n);
        chk("divu0_cycles", 64'(n), 64'd10);
        chk("divu0_done", 64'(Done), 64'd1);
        chk("divu0_hi", 64'(HI), 64'h1234_5678);
        chk("divu0_lo", 64'(LO), 64'h1234_5678);

        launch(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_busy(n);
        chk("mult_cycles", 64'(n), 64'd5);
        chk("mult_done", 64'(Done), 64'd1);
        chk("mult_hi", 64'(HI), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(LO), 64'hFFFF_FFFA);

        launch(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_busy(n);
        chk("multu_cycles", 64'(n), 64'd5);
        chk("multu_hi", 64'(HI), 64'h0000_0002);
        chk("multu_lo", 64'(LO), 64'hFFFF_FFFA);

        launch(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_busy(n);
        chk("div_cycles", 64'(n), 64'd10);
        chk("div_lo", 64'(LO), 64'hFFFF_FFFD);
        chk("div_hi", 64'(HI), 64'hFFFF_FFFF);

        launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n);
        chk("divovf_lo", 64'(LO), 64'h8000_0000);
        chk("divovf_hi", 64'(HI), 64'h0);

        launch(3'd4, 32'd100, 32'd7);
        wait_busy(n);
        chk("divu_lo", 64'(LO), 64'd14);
        chk("divu_hi", 64'(HI), 64'd2);

        // mtlo and div issued while a mult is in flight must be dropped
        launch(3'd1, 32'd6, 32'd7);
        tick();
        tick();
        MDUOp = 3'd6; A = 32'h5; Start = 1'b1;
        tick();
        MDUOp = 3'd3; A = 32'd1; B = 32'd1;
        tick();
        Start = 1'b0;
        chk("inflight_busy", 64'(Busy), 64'd1);
        chk("inflight_lo_hold", 64'(LO), 64'd14);
        chk("inflight_hi_hold", 64'(HI), 64'd2);
        wait_busy(n);
        chk("inflight_cycles", 64'(n + 4), 64'd5);
        chk("inflight_hi", 64'(HI), 64'd0);
        chk("inflight_lo", 64'(LO), 64'd42);

        launch(3'd6, 32'h5, 32'h0);
        chk("mtlo5_lo", 64'(LO), 64'h5);
        chk("mtlo5_busy", 64'(Busy), 64'd0);
        chk("mtlo5_done", 64'(Done), 64'd0);

        launch(3'd0, 32'hDEAD, 32'h1);
        launch(3'd7, 32'hBEEF, 32'h1);
        chk("nop_busy", 64'(Busy), 64'd0);
        chk("nop_hi", 64'(HI), 64'd0);
        chk("nop_lo", 64'(LO), 64'h5);

        // asynchronous abort mid-divide
        launch(3'd3, 32'd100, 32'd3);
        repeat (3) tick();
        #2 Rst = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hi", 64'(HI), 64'd0);
        chk("abort_lo", 64'(LO), 64'd0);
        tick();
        tick();
        Rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_done = saw_done | Done;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        chk("abort_lo_after", 64'(LO), 64'd0);

        launch2(3'd1, 16'h8000, 16'h8000);
        wait_busy2(n);
        chk("w16_mult_cycles", 64'(n), 64'd1);
        chk("w16_mult_done", 64'(Done2), 64'd1);
        chk("w16_mult_hi", 64'(HI2), 64'h4000);
        chk("w16_mult_lo", 64'(LO2), 64'h0);
        launch2(3'd2, 16'd3, 16'd5);
        chk("w16_b2b_busy", 64'(Busy2), 64'd1);
        wait_busy2(n);
        chk("w16_multu_cycles", 64'(n), 64'd1);
        chk("w16_multu_lo", 64'(LO2), 64'hF);
        chk("w16_multu_hi", 64'(HI2), 64'h0);
        launch2(3'd3, 16'hFFF9, 16'd2);
        wait_busy2(n);
        chk("w16_div_cycles", 64'(n), 64'd3);
        chk("w16_div_lo", 64'(LO2), 64'hFFFD);
        chk("w16_div_hi", 64'(HI2), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, as the operand and HI/LO width.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, as the busy cycles for mult/multu (legal range 1..255).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, as the busy cycles for div/divu (legal range 1..255).
REQ-004 Clk  input  1  the one clock; all state SHALL update on the rising edge.
REQ-005 Rst  input  1  reset, asynchronous and active-low.
REQ-006 Start  input  1  high for one cycle SHALL launch the operation given by MDUOp.
REQ-007 MDUOp  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-008 A  input  WIDTH  first operand (dividend, multiplicand, or mthi/mtlo data).
REQ-009 B  input  WIDTH  second operand (divisor or multiplier).
REQ-010 Busy  output  1  high while a multiply or divide is in flight.
REQ-011 Done  output  1  one-cycle pulse when HI/LO take a multiply or divide result.
REQ-012 HI  output  WIDTH  the HI register (product upper half, or remainder).
REQ-013 LO  output  WIDTH  the LO register (product lower half, or quotient).

Function
REQ-014 The FSM SHALL have two states, IDLE and BUSY, plus an 8-bit down-counter.
REQ-015 IDLE with Start=1 and MDUOp in {1..4}: A and B SHALL be sampled at that edge, the state SHALL go to BUSY, and the counter SHALL load MULT_CYCLES or DIV_CYCLES.
REQ-016 BUSY: the counter SHALL decrement each edge; on the edge where it reaches 0, HI/LO SHALL load the result, the state SHALL return to IDLE, and Done SHALL go high for exactly the following cycle.
REQ-017 Busy SHALL be high for exactly N cycles, where N is the parameter for the operation: if Start is at edge k, Busy is high after edge k through edge k+N.
REQ-018 mult SHALL form the signed 2*WIDTH product and multu the unsigned product; HI SHALL get the upper WIDTH bits and LO the lower WIDTH bits.
REQ-019 div SHALL truncate the quotient toward zero and give the remainder the sign of the dividend; divu SHALL divide unsigned.
REQ-020 div with A = most-negative and B = -1 SHALL give LO = A and HI = 0 (wrap, no trap).
REQ-021 Divide by zero (div or divu with B=0) SHALL still assert Busy for DIV_CYCLES and pulse Done, but HI and LO SHALL remain unchanged.
REQ-022 mthi/mtlo in IDLE SHALL write A to HI/LO at that edge, with no Busy and no Done.
REQ-023 Start during BUSY SHALL be ignored for every MDUOp, including mthi/mtlo; the in-flight operation SHALL be unaffected.
REQ-024 Operand changes on A/B after the launch edge SHALL NOT affect the result.
REQ-025 MDUOp 0 or 7 with Start=1 SHALL have no effect.
REQ-026 HI/LO SHALL be readable at all times; during BUSY they SHALL hold their pre-launch values.
REQ-027 Back-to-back operation: Start in the cycle that Done is high (state IDLE) SHALL be accepted.

Reset
REQ-028 Rst=0 SHALL immediately, without waiting for Clk, force state IDLE, counter 0, Busy=0, Done=0, HI=0 and LO=0.
REQ-029 Rst asserted during BUSY SHALL abort the operation: no Done pulse, and no result is written after release.
REQ-030 Start SHALL be ignored while Rst=0; the first accepted Start is at the first rising edge with Rst=1.

Verification
REQ-031 mult with A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 div with A=-7 (0xFFFFFFF9), B=2 -> Busy high 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu 7/0 with HI=LO=0x12345678 -> HI/LO unchanged after Done.
REQ-033 div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Launch mult, then during BUSY issue mtlo A=0x5 and div -> both ignored; final HI/LO hold the mult result; mtlo A=0x5 in IDLE -> LO=0x5 next cycle, Busy stays 0.
REQ-035 Launch div, pull Rst low asynchronously at cycle 4 -> Busy=0, HI=LO=0 before the next Clk edge; after release, no Done pulse.
REQ-036 Re-run with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3 -> mult 0x8000*0x8000 gives HI=0x4000, LO=0 with Busy high 1 cycle; Start on the Done cycle is accepted.
